// File: rtl/req_accept_tracker_pkg.sv
// Shared types and sizing helpers for the request/accept tracker.
package req_accept_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        BUSY    = 2'd2
    } state_t;

    // Age must be able to hold TIMEOUT itself.
    function automatic int age_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/req_accept_tracker_if.sv
// Per-channel strobes and status bundle between protocol agents and the tracker.
interface req_accept_tracker_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0] request;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] cancel;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] cancelled;
    logic [NUM_CH-1:0] timed_out;
    logic [NUM_CH-1:0] proto_err;
    logic [CNT_W-1:0]  accept_cnt;

    modport master (
        output request, accept, cancel,
        input  pending, busy, done, cancelled, timed_out, proto_err, accept_cnt
    );

    modport slave (
        input  request, accept, cancel,
        output pending, busy, done, cancelled, timed_out, proto_err, accept_cnt
    );
endinterface

// File: rtl/req_accept_channel.sv
// One tracker channel: IDLE/PENDING/BUSY FSM with age and busy-window counters.
// Define REQ_ACCEPT_TRACKER_SVA_EN to compile in the channel assertions and covers.
module req_accept_channel
    import req_accept_tracker_pkg::*;
#(
    parameter int MIN_DELAY   = 4,
    parameter int BUSY_CYCLES = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_request,
    input  logic i_accept,
    input  logic i_cancel,
    output logic o_pending,
    output logic o_busy,
    output logic o_done,
    output logic o_cancelled,
    output logic o_timed_out,
    output logic o_proto_err,
    output logic o_accept_legal
);

    localparam int AW = age_width(TIMEOUT);
    localparam int BW = cnt_width(BUSY_CYCLES);
    localparam logic [AW-1:0] MIN_AGE   = AW'(MIN_DELAY);
    localparam logic [AW-1:0] MAX_AGE   = AW'(TIMEOUT);
    localparam logic [BW-1:0] BCNT_INIT = BW'(BUSY_CYCLES - 1);

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_age, w_age_nxt;
    logic [BW-1:0] r_bcnt, w_bcnt_nxt;
    logic          r_done, w_done_nxt;
    logic          r_cancelled, w_cancelled_nxt;
    logic          r_timed_out, w_timed_out_nxt;
    logic          r_proto_err, w_proto_err_nxt;

    always_comb begin
        w_state_nxt     = r_state;
        w_age_nxt       = r_age;
        w_bcnt_nxt      = r_bcnt;
        w_done_nxt      = 1'b0;
        w_cancelled_nxt = 1'b0;
        w_timed_out_nxt = 1'b0;
        w_proto_err_nxt = r_proto_err;
        o_accept_legal  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_request) begin
                    w_state_nxt = PENDING;
                    w_age_nxt   = AW'(1);
                end
                if (i_accept) w_proto_err_nxt = 1'b1;
            end
            PENDING: begin
                if (i_cancel) begin
                    w_state_nxt     = IDLE;
                    w_age_nxt       = '0;
                    w_cancelled_nxt = 1'b1;
                end else if (i_accept && (r_age >= MIN_AGE)) begin
                    w_state_nxt    = BUSY;
                    w_age_nxt      = '0;
                    w_bcnt_nxt     = BCNT_INIT;
                    w_done_nxt     = (BCNT_INIT == '0);
                    o_accept_legal = 1'b1;
                end else if (i_accept) begin
                    w_proto_err_nxt = 1'b1;
                    w_age_nxt       = r_age + AW'(1);
                end else if (r_age == MAX_AGE) begin
                    w_state_nxt     = IDLE;
                    w_age_nxt       = '0;
                    w_timed_out_nxt = 1'b1;
                end else begin
                    w_age_nxt = r_age + AW'(1);
                end
            end
            BUSY: begin
                if (i_request) w_proto_err_nxt = 1'b1;
                if (r_bcnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_bcnt_nxt = r_bcnt - BW'(1);
                    // done is registered, so raise it entering the final busy cycle
                    w_done_nxt = (r_bcnt == BW'(1));
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_age       <= '0;
            r_bcnt      <= '0;
            r_done      <= 1'b0;
            r_cancelled <= 1'b0;
            r_timed_out <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_age       <= w_age_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_done      <= w_done_nxt;
            r_cancelled <= w_cancelled_nxt;
            r_timed_out <= w_timed_out_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    assign o_pending   = (r_state == PENDING);
    assign o_busy      = (r_state == BUSY);
    assign o_done      = r_done;
    assign o_cancelled = r_cancelled;
    assign o_timed_out = r_timed_out;
    assign o_proto_err = r_proto_err;

`ifdef REQ_ACCEPT_TRACKER_SVA_EN
    a_busy_rise: assert property (@(posedge clk) disable iff (rst)
        $rose(o_busy) |-> $past(o_accept_legal));
    a_excl: assert property (@(posedge clk) disable iff (rst)
        !(o_pending && o_busy));
    a_done_busy: assert property (@(posedge clk) disable iff (rst)
        o_done |-> o_busy);
    c_accept_min: cover property (@(posedge clk) disable iff (rst)
        o_pending && i_accept && !i_cancel && (r_age == MIN_AGE));
    c_cancel: cover property (@(posedge clk) disable iff (rst)
        o_pending && i_cancel);
    c_timeout: cover property (@(posedge clk) disable iff (rst)
        o_timed_out);
`endif

endmodule

// File: rtl/req_accept_tracker.sv
// Multi-channel request/accept/cancel tracker with a saturating legal-accept counter.
module req_accept_tracker
    import req_accept_tracker_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int MIN_DELAY   = 4,
    parameter int BUSY_CYCLES = 8,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16
) (
    input logic                 clk,
    input logic                 rst,
    req_accept_tracker_if.slave bus
);

    localparam int PW = $clog2(NUM_CH + 1);
    localparam int SW = CNT_W + PW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] w_pending, w_busy, w_done, w_cancelled;
    logic [NUM_CH-1:0] w_timed_out, w_proto_err, w_accept_legal;
    logic [PW-1:0]     w_pop;
    logic [SW-1:0]     w_sum;
    logic [CNT_W-1:0]  r_accept_cnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        req_accept_channel #(
            .MIN_DELAY   (MIN_DELAY),
            .BUSY_CYCLES (BUSY_CYCLES),
            .TIMEOUT     (TIMEOUT)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .i_request      (bus.request[g]),
            .i_accept       (bus.accept[g]),
            .i_cancel       (bus.cancel[g]),
            .o_pending      (w_pending[g]),
            .o_busy         (w_busy[g]),
            .o_done         (w_done[g]),
            .o_cancelled    (w_cancelled[g]),
            .o_timed_out    (w_timed_out[g]),
            .o_proto_err    (w_proto_err[g]),
            .o_accept_legal (w_accept_legal[g])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_CH; i++) w_pop = w_pop + PW'(w_accept_legal[i]);
    end

    // Widened sum lets one compare detect overflow from any popcount.
    assign w_sum = SW'(r_accept_cnt) + SW'(w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       r_accept_cnt <= '0;
        else if (w_sum > SW'(CNT_MAX)) r_accept_cnt <= CNT_MAX;
        else                           r_accept_cnt <= w_sum[CNT_W-1:0];
    end

    assign bus.pending    = w_pending;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.cancelled  = w_cancelled;
    assign bus.timed_out  = w_timed_out;
    assign bus.proto_err  = w_proto_err;
    assign bus.accept_cnt = r_accept_cnt;

endmodule

// File: tb/tb_req_accept_tracker.sv
// Directed bench for req_accept_tracker: default instance plus a CNT_W=3 instance for saturation.
module tb_req_accept_tracker;
    import req_accept_tracker_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] acc = '0;
    logic [3:0] can = '0;
    int         n_checks = 0;
    int         n_errors = 0;

    req_accept_tracker_if #(.NUM_CH(4), .CNT_W(16)) if_a ();
    req_accept_tracker_if #(.NUM_CH(4), .CNT_W(3))  if_s ();

    assign if_a.request = req;
    assign if_a.accept  = acc;
    assign if_a.cancel  = can;
    assign if_s.request = req;
    assign if_s.accept  = acc;
    assign if_s.cancel  = can;

    req_accept_tracker #(.NUM_CH(4), .MIN_DELAY(4), .BUSY_CYCLES(8), .TIMEOUT(64), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    req_accept_tracker #(.NUM_CH(4), .MIN_DELAY(4), .BUSY_CYCLES(8), .TIMEOUT(64), .CNT_W(3)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (if_s.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        step();
        chk("rst_pending", if_a.pending, 0);
        chk("rst_busy", if_a.busy, 0);
        chk("rst_done", if_a.done, 0);
        chk("rst_proto", if_a.proto_err, 0);
        chk("rst_cnt", if_a.accept_cnt, 0);

        // ch0: legal accept at t+4
        req = 4'b0001; step(); req = '0;
        chk("c0_pending_t1", if_a.pending, 4'b0001);
        chk("c0_busy_t1", if_a.busy, 0);
        repeat (3) step();
        chk("c0_pending_t4", if_a.pending, 4'b0001);
        acc = 4'b0001; step(); acc = '0;
        chk("c0_busy_t5", if_a.busy, 4'b0001);
        chk("c0_pending_t5", if_a.pending, 0);
        chk("c0_cnt", if_a.accept_cnt, 1);
        repeat (6) step();
        chk("c0_done_t11", if_a.done, 0);
        chk("c0_busy_t11", if_a.busy, 4'b0001);
        step();
        chk("c0_done_t12", if_a.done, 4'b0001);
        chk("c0_busy_t12", if_a.busy, 4'b0001);
        step();
        chk("c0_busy_t13", if_a.busy, 0);
        chk("c0_done_t13", if_a.done, 0);
        chk("c0_proto", if_a.proto_err, 0);

        // ch1: early accept at t+2, legal accept at t+4
        req = 4'b0010; step(); req = '0;
        step();
        acc = 4'b0010; step(); acc = '0;
        chk("c1_proto_t3", if_a.proto_err, 4'b0010);
        chk("c1_pending_t3", if_a.pending, 4'b0010);
        step();
        acc = 4'b0010; step(); acc = '0;
        chk("c1_busy_t5", if_a.busy, 4'b0010);
        chk("c1_cnt", if_a.accept_cnt, 2);
        repeat (8) step();
        chk("c1_idle", if_a.busy, 0);

        // ch2: cancel beats a same-cycle accept
        req = 4'b0100; step(); req = '0;
        repeat (4) step();
        acc = 4'b0100; can = 4'b0100; step(); acc = '0; can = '0;
        chk("c2_cancelled", if_a.cancelled, 4'b0100);
        chk("c2_pending", if_a.pending, 0);
        chk("c2_busy", if_a.busy, 0);
        step();
        chk("c2_cancel_pulse", if_a.cancelled, 0);
        chk("c2_busy_after", if_a.busy, 0);
        chk("c2_cnt", if_a.accept_cnt, 2);

        // ch3: timeout once age reaches 64
        req = 4'b1000; step(); req = '0;
        repeat (63) step();
        chk("c3_pending_t64", if_a.pending, 4'b1000);
        chk("c3_to_t64", if_a.timed_out, 0);
        step();
        chk("c3_to_t65", if_a.timed_out, 4'b1000);
        chk("c3_pending_t65", if_a.pending, 0);
        step();
        chk("c3_to_pulse", if_a.timed_out, 0);

        // all channels accept together, with a stray request on ch0 while busy
        req = 4'b1111; step(); req = '0;
        repeat (3) step();
        acc = 4'b1111; step(); acc = '0;
        chk("all_busy", if_a.busy, 4'b1111);
        chk("all_cnt", if_a.accept_cnt, 6);
        chk("all_cnt_sat", if_s.accept_cnt, 6);
        step();
        req = 4'b0001; step(); req = '0;
        chk("busy_req_proto", if_a.proto_err, 4'b0011);
        chk("busy_req_dropped", if_a.pending, 0);
        repeat (6) step();
        chk("all_idle", if_a.busy, 0);

        req = 4'b1111; step(); req = '0;
        repeat (3) step();
        acc = 4'b1111; step(); acc = '0;
        chk("all2_cnt", if_a.accept_cnt, 10);
        chk("all2_cnt_sat", if_s.accept_cnt, 7);
        repeat (8) step();
        chk("all2_idle", if_a.busy, 0);

        // accept with nothing pending
        acc = 4'b0100; step(); acc = '0;
        chk("idle_acc_proto", if_a.proto_err, 4'b0111);
        chk("idle_acc_cnt", if_a.accept_cnt, 10);

        // asynchronous reset in the middle of ch0's busy window
        req = 4'b0001; step(); req = '0;
        repeat (3) step();
        acc = 4'b0001; step(); acc = '0;
        chk("rb_busy", if_a.busy, 4'b0001);
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("rb_busy_async", if_a.busy, 0);
        chk("rb_cnt_async", if_a.accept_cnt, 0);
        chk("rb_cnt_sat_async", if_s.accept_cnt, 0);
        chk("rb_proto_async", if_a.proto_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rb_no_done", {if_a.done, if_a.busy}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/req_accept_tracker.md
Name: req_accept_tracker

Overview:
- Multi-channel, parametrised tracker for request/accept/cancel transactions.
- Each channel waits for an accept that arrives no earlier than a minimum delay and is not cancelled. It then asserts busy for a fixed window.
- Catches early accepts, stray requests and stalled requests (timeout).
- Sits beside protocol agents as a checkable reference model and a status source.

Parameters:
- NUM_CH, 4, number of independent channels.
- MIN_DELAY, 4, minimum cycles from request to a legal accept (accept earliest at request cycle + MIN_DELAY).
- BUSY_CYCLES, 8, number of cycles busy stays high after an accepted request.
- TIMEOUT, 64, maximum pending age before the request is abandoned; must be > MIN_DELAY.
- CNT_W, 16, width of the accepted-transaction counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- request  in  NUM_CH  per-channel request strobe.
- accept  in  NUM_CH  per-channel accept strobe.
- cancel  in  NUM_CH  per-channel cancel strobe.
- pending  out  NUM_CH  channel is waiting for accept.
- busy  out  NUM_CH  channel is in its busy window.
- done  out  NUM_CH  1-cycle pulse on the last busy cycle.
- cancelled  out  NUM_CH  1-cycle pulse, pending request cancelled.
- timed_out  out  NUM_CH  1-cycle pulse, pending request abandoned.
- proto_err  out  NUM_CH  sticky protocol-error flag; cleared only by rst.
- accept_cnt  out  CNT_W  total legal accepts across all channels; saturates at all-ones.

Behaviour:
- Reset (async assert, sync-safe deassert): all channels IDLE. Every output 0, accept_cnt 0, age counters 0.
- Clock and reset are fixed: one clock, reset is asynchronous and active-high.
- Per-channel FSM with states IDLE, PENDING, BUSY. All outputs are registered; pending and busy are decodes of the state register.
- IDLE:
  - request=1 -> PENDING, age<=1.
  - accept or cancel in IDLE -> ignored; accept alone sets proto_err.
- PENDING, in priority order:
  - cancel=1 -> IDLE, cancelled pulse. Cancel beats a same-cycle accept.
  - accept=1 and age>=MIN_DELAY -> BUSY, bcnt<=BUSY_CYCLES-1, accept_cnt increments.
  - accept=1 and age<MIN_DELAY -> proto_err set, stay PENDING, age still advances.
  - age==TIMEOUT -> IDLE, timed_out pulse.
  - otherwise age increments.
  - request in PENDING is ignored: no restart, no error.
- BUSY:
  - Decrement bcnt each cycle. When bcnt==0: -> IDLE, done pulse in the same cycle as the final busy=1.
  - request in BUSY sets proto_err and is dropped.
  - accept or cancel in BUSY is ignored.
- Timing example: request at cycle t -> pending=1 at t+1. Legal accept at t+4 (MIN_DELAY=4) -> busy=1 from t+5 through t+12, done at t+12, idle at t+13.
- Invariant: busy rises only in the cycle after a legal, non-cancelled accept.
- accept_cnt: when several channels accept legally in the same cycle, add the popcount. Saturate, do not wrap.
- Age counter width is clog2(TIMEOUT+1) and never exceeds TIMEOUT.
- rst asserted mid-transaction: immediate return to IDLE, no done/cancelled/timed_out pulse.

Optional Feature:
- Macro REQ_ACCEPT_TRACKER_SVA_EN.
- Defined: per-channel concurrent assertions compiled in:
  - rise of busy implies the accepted-request sequence triggered;
  - pending and busy never both high;
  - done implies busy.
  - Cover properties: accept exactly at MIN_DELAY; cancel during PENDING; timeout.
  - All disabled iff rst.
- Undefined: no assertion or cover code; RTL behaviour identical.

Decomposition:
- Package req_accept_tracker_pkg: state enum (IDLE, PENDING, BUSY), and a function computing the age width from TIMEOUT.
- Sub-module req_accept_channel: one FSM plus age and bcnt counters, instantiated NUM_CH times by generate.
- Top holds the popcount and the saturating accept_cnt.

Test Plan:
- ch0 request at t, accept at t+4 -> busy[0] high t+5..t+12, done[0] at t+12, accept_cnt=1, proto_err=0.
- ch1 request at t, accept at t+2 then t+4 -> proto_err[1]=1 from t+3, busy[1] rises t+5.
- ch2 request at t, accept and cancel both at t+5 -> cancelled[2] at t+6, busy[2] never rises, accept_cnt unchanged.
- ch3 request, no accept or cancel -> timed_out[3] pulse after age reaches 64, then pending[3]=0.
- All 4 channels legal accept in the same cycle -> accept_cnt +4. Preload near all-ones (CNT_W=3) -> holds at 7.
- rst pulsed mid-BUSY on ch0 (asynchronous, between edges) -> busy[0]=0 immediately, no done pulse, accept_cnt=0.
